// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - command sequencer driving the 32 x 16-bit register file strobe interface
//
// Takes one register-level command (MOV, LDI, INC, DEC, SWAP, RD) per
// cmd_valid/cmd_ready handshake. It expands the command into one file strobe
// per cycle, then returns one response per command on rsp_valid/rsp_ready.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_op/cmd_a/cmd_b/cmd_imm fields
//   rsp_valid/rsp_ready    response handshake; rsp_data, rsp_err
//   rf_read/rf_write/rf_writeu/rf_inc/rf_dec, rf_id, rf_din   file control
//   rf_dout                file read data, valid only while rf_read=1
module regfile_sequencer #(
    parameter int ID_W     = 6,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [ID_W-1:0] cmd_a,
    input  logic [ID_W-1:0] cmd_b,
    input  logic [15:0]     cmd_imm,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [15:0]     rsp_data,
    output logic            rsp_err,
    output logic            rf_read,
    output logic            rf_write,
    output logic            rf_writeu,
    output logic            rf_inc,
    output logic            rf_dec,
    output logic [ID_W-1:0] rf_id,
    output logic [15:0]     rf_din,
    input  logic [15:0]     rf_dout
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, WRU, STEP, RESP} state_t;

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SWAP = 3'b100;
    localparam logic [2:0] OP_RD   = 3'b101;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [ID_W-1:0] a_q, a_d, b_q, b_d;
    logic [15:0]     imm_q, imm_d;
    logic [15:0]     t0_q, t0_d, t1_q, t1_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic            a_bad, b_bad, uses_b, op_bad;

    // Only ids the op actually consumes are range checked.
    always_comb begin
        a_bad  = 32'(cmd_a) >= NUM_REGS;
        b_bad  = 32'(cmd_b) >= NUM_REGS;
        uses_b = (cmd_op == OP_MOV) || (cmd_op == OP_SWAP);
        op_bad = cmd_op > OP_RD;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rf_read    = 1'b0;
        rf_write   = 1'b0;
        rf_writeu  = 1'b0;
        rf_inc     = 1'b0;
        rf_dec     = 1'b0;
        rf_id      = '0;
        rf_din     = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    imm_d = cmd_imm;
                    if (op_bad || a_bad || (uses_b && b_bad)) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = RESP;
                    end else begin
                        rsp_err_d = 1'b0;
                        case (cmd_op)
                            OP_LDI:         state_d = WR0;
                            OP_INC, OP_DEC: state_d = STEP;
                            default:        state_d = RD0;
                        endcase
                    end
                end
            end
            RD0: begin
                rf_read = 1'b1;
                rf_id   = (op_q == OP_MOV) ? b_q : a_q;
                t0_d    = rf_dout;
                case (op_q)
                    OP_MOV:  state_d = WR0;
                    OP_SWAP: state_d = RD1;
                    default: begin
                        rsp_data_d = rf_dout;
                        state_d    = RESP;
                    end
                endcase
            end
            RD1: begin
                rf_read = 1'b1;
                rf_id   = b_q;
                t1_d    = rf_dout;
                state_d = WR0;
            end
            WR0: begin
                rf_write = 1'b1;
                rf_id    = a_q;
                case (op_q)
                    OP_MOV: begin
                        rf_din     = t0_q;
                        rsp_data_d = t0_q;
                        state_d    = RESP;
                    end
                    OP_SWAP: begin
                        rf_din  = t1_q;
                        state_d = WR1;
                    end
                    default: begin
                        // LDI writes the low byte with a full write, then
                        // patches the high byte through writeu.
                        rf_din  = {8'h00, imm_q[7:0]};
                        state_d = WRU;
                    end
                endcase
            end
            WR1: begin
                rf_write   = 1'b1;
                rf_id      = b_q;
                rf_din     = t0_q;
                rsp_data_d = t0_q;
                state_d    = RESP;
            end
            WRU: begin
                rf_writeu  = 1'b1;
                rf_id      = a_q;
                rf_din     = {8'h00, imm_q[15:8]};
                rsp_data_d = imm_q;
                state_d    = RESP;
            end
            STEP: begin
                rf_inc     = (op_q == OP_INC);
                rf_dec     = (op_q != OP_INC);
                rf_id      = a_q;
                rsp_data_d = '0;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rsp_data = rsp_data_q;
        rsp_err  = rsp_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - randomized self-checking bench for regfile_sequencer
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [5:0]  cmd_a, cmd_b;
    logic [15:0] cmd_imm;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        rf_read, rf_write, rf_writeu, rf_inc, rf_dec;
    logic [5:0]  rf_id;
    logic [15:0] rf_din, rf_dout;

    logic [15:0] rf_mem   [32] = '{default: 16'h0000};
    logic [15:0] ref_regs [32] = '{default: 16'h0000};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.ID_W(6), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rf_read(rf_read), .rf_write(rf_write), .rf_writeu(rf_writeu),
        .rf_inc(rf_inc), .rf_dec(rf_dec), .rf_id(rf_id),
        .rf_din(rf_din), .rf_dout(rf_dout)
    );

    // Register file model; the bus carries junk whenever it is not being read.
    assign rf_dout = rf_read ? rf_mem[rf_id[4:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (rf_write)       rf_mem[rf_id[4:0]]       <= rf_din;
        else if (rf_writeu) rf_mem[rf_id[4:0]][15:8] <= rf_din[7:0];
        else if (rf_inc)    rf_mem[rf_id[4:0]]       <= rf_mem[rf_id[4:0]] + 16'd1;
        else if (rf_dec)    rf_mem[rf_id[4:0]]       <= rf_mem[rf_id[4:0]] - 16'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0 none, 1 read, 2 write, 3 writeu, 4 inc, 5 dec
    function automatic logic [2:0] scode();
        if (rf_read)   return 3'd1;
        if (rf_write)  return 3'd2;
        if (rf_writeu) return 3'd3;
        if (rf_inc)    return 3'd4;
        if (rf_dec)    return 3'd5;
        return 3'd0;
    endfunction

    function automatic logic quiet();
        return ({rf_read, rf_write, rf_writeu, rf_inc, rf_dec} == 5'b0) &&
               (rf_id == 6'd0) && (rf_din == 16'h0);
    endfunction

    task automatic check_regs();
        int mism = 0;
        for (int i = 0; i < 32; i++) if (rf_mem[i] !== ref_regs[i]) mism++;
        check("regs", 32'(mism), 32'd0);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b,
                           input logic [15:0] imm, input int hold);
        logic        err;
        int          exp_lat, n_exp, cyc, k;
        logic [15:0] exp_data, ra, rb, held;
        logic [2:0]  e_code [4];
        logic [5:0]  e_id   [4];
        logic [15:0] e_din  [4];

        ra  = ref_regs[a[4:0]];
        rb  = ref_regs[b[4:0]];
        err = (op > 3'd5) || (a >= 6'd32) || ((op == 3'd0 || op == 3'd4) && b >= 6'd32);
        n_exp = 0; exp_data = 16'h0; exp_lat = 1;
        if (!err) begin
            case (op)
                3'd0: begin
                    exp_lat = 3; n_exp = 2; exp_data = rb;
                    e_code[0] = 1; e_id[0] = b; e_din[0] = 0;
                    e_code[1] = 2; e_id[1] = a; e_din[1] = rb;
                    ref_regs[a[4:0]] = rb;
                end
                3'd1: begin
                    exp_lat = 3; n_exp = 2; exp_data = imm;
                    e_code[0] = 2; e_id[0] = a; e_din[0] = {8'h00, imm[7:0]};
                    e_code[1] = 3; e_id[1] = a; e_din[1] = {8'h00, imm[15:8]};
                    ref_regs[a[4:0]] = imm;
                end
                3'd2, 3'd3: begin
                    exp_lat = 2; n_exp = 1;
                    e_code[0] = (op == 3'd2) ? 3'd4 : 3'd5; e_id[0] = a; e_din[0] = 0;
                    ref_regs[a[4:0]] = (op == 3'd2) ? ra + 16'd1 : ra - 16'd1;
                end
                3'd4: begin
                    exp_lat = 5; n_exp = 4; exp_data = ra;
                    e_code[0] = 1; e_id[0] = a; e_din[0] = 0;
                    e_code[1] = 1; e_id[1] = b; e_din[1] = 0;
                    e_code[2] = 2; e_id[2] = a; e_din[2] = rb;
                    e_code[3] = 2; e_id[3] = b; e_din[3] = ra;
                    ref_regs[a[4:0]] = rb;
                    ref_regs[b[4:0]] = ra;
                end
                default: begin
                    exp_lat = 2; n_exp = 1; exp_data = ra;
                    e_code[0] = 1; e_id[0] = a; e_din[0] = 0;
                end
            endcase
        end

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_imm = imm;
        rsp_ready = 1'b0;
        cyc = 0;
        while (!cmd_ready && cyc < 10) begin @(negedge clk); cyc++; end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        cyc = 1; k = 0;
        while (!rsp_valid && cyc < 12) begin
            check("onehot", 32'($countones({rf_read, rf_write, rf_writeu, rf_inc, rf_dec}) <= 1), 32'd1);
            if (k < n_exp) begin
                check("strobe", 32'(scode()), 32'(e_code[k]));
                check("rf_id", 32'(rf_id), 32'(e_id[k]));
                check("rf_din", 32'(rf_din), 32'(e_din[k]));
            end else begin
                check("extra_strobe", 32'(quiet()), 32'd1);
            end
            k++;
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_err", 32'(rsp_err), 32'(err));
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("resp_quiet", 32'(quiet()), 32'd1);

        held = rsp_data;
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(held));
            check("hold_err", 32'(rsp_err), 32'(err));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_quiet", 32'(quiet()), 32'd1);
        end
        cmd_valid = (hold > 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("back_idle", 32'(cmd_ready), 32'd1);
        check("idle_quiet", 32'(quiet()), 32'd1);
        check_regs();
    endtask

    task automatic reset_mid_swap(input logic [5:0] a, input logic [5:0] b);
        int cyc;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = a; cmd_b = b; cmd_imm = 16'h0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (!rf_write && cyc < 10) begin @(posedge clk); #1; cyc++; end
        check("swap_reached_wr0", 32'(rf_write), 32'd1);
        // The WR0 write lands on the reset edge itself.
        ref_regs[a[4:0]] = ref_regs[b[4:0]];
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_quiet", 32'(quiet()), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_valid", 32'(rsp_valid), 32'd0);
            check("post_rst_quiet", 32'(quiet()), 32'd1);
        end
        check_regs();
    endtask

    initial begin
        logic [2:0] op;
        logic [5:0] a, b;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 6'd0; cmd_b = 6'd0;
        cmd_imm = 16'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp", 32'({rsp_err, rsp_data}), 32'd0);
        check("reset_quiet", 32'(quiet()), 32'd1);

        run_cmd(3'd1, 6'd3, 6'd0, 16'hBEEF, 0);
        run_cmd(3'd5, 6'd3, 6'd0, 16'h0, 0);
        run_cmd(3'd1, 6'd5, 6'd0, 16'hFFFF, 0);
        run_cmd(3'd2, 6'd5, 6'd63, 16'h0, 0);
        run_cmd(3'd5, 6'd5, 6'd0, 16'h0, 0);
        run_cmd(3'd3, 6'd5, 6'd0, 16'h0, 0);
        run_cmd(3'd5, 6'd5, 6'd0, 16'h0, 0);
        run_cmd(3'd1, 6'd1, 6'd0, 16'h1234, 0);
        run_cmd(3'd1, 6'd2, 6'd0, 16'hABCD, 0);
        run_cmd(3'd4, 6'd1, 6'd2, 16'h0, 0);
        run_cmd(3'd5, 6'd1, 6'd0, 16'h0, 0);
        run_cmd(3'd5, 6'd2, 6'd0, 16'h0, 0);
        run_cmd(3'd1, 6'd7, 6'd0, 16'h5A3C, 0);
        run_cmd(3'd4, 6'd7, 6'd7, 16'h0, 0);
        run_cmd(3'd0, 6'd9, 6'd9, 16'h0, 0);
        run_cmd(3'd0, 6'd40, 6'd2, 16'h0, 0);
        run_cmd(3'd7, 6'd1, 6'd2, 16'h0, 0);
        run_cmd(3'd6, 6'd1, 6'd2, 16'h0, 0);
        run_cmd(3'd4, 6'd1, 6'd33, 16'h0, 0);
        run_cmd(3'd2, 6'd32, 6'd0, 16'h0, 0);
        run_cmd(3'd5, 6'd2, 6'd0, 16'h0, 4);
        run_cmd(3'd0, 6'd4, 6'd2, 16'h0, 0);

        run_cmd(3'd1, 6'd10, 6'd0, 16'h1111, 0);
        run_cmd(3'd1, 6'd11, 6'd0, 16'h2222, 0);
        reset_mid_swap(6'd10, 6'd11);
        run_cmd(3'd5, 6'd10, 6'd0, 16'h0, 0);
        run_cmd(3'd5, 6'd11, 6'd0, 16'h0, 0);

        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            a  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
            b  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
            run_cmd(op, a, b, 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Command-side initiator for the 32 x 16-bit register file.
- Accepts one register-level command per valid/ready handshake. Sequences it into the file's strobe interface (read, write, writeu, inc, dec, id, din), one strobe per cycle.
- Samples the file's dout bus and returns one response per command over a valid/ready response channel.
- Sits between the control unit and the register file; it is the only driver of the file's control lines.

Parameters:
- ID_W, 6, width of register id fields and rf_id.
- NUM_REGS, 32, number of implemented registers; any id >= NUM_REGS is illegal.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  000 MOV, 001 LDI, 010 INC, 011 DEC, 100 SWAP, 101 RD, 110/111 illegal.
- cmd_a  input  ID_W  primary register id.
- cmd_b  input  ID_W  secondary register id (MOV source, SWAP partner).
- cmd_imm  input  16  LDI immediate.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes response.
- rsp_data  output  16  response data.
- rsp_err  output  1  command rejected.
- rf_read  output  1  register file read enable.
- rf_write  output  1  full 16-bit write.
- rf_writeu  output  1  upper-byte write (file stores din[7:0] into R[id][15:8]).
- rf_inc  output  1  increment R[id].
- rf_dec  output  1  decrement R[id].
- rf_id  output  ID_W  register select.
- rf_din  output  16  write data.
- rf_dout  input  16  register file output; valid only while rf_read=1.

Behaviour:
- States: IDLE, RD0, RD1, WR0, WR1, WRU, STEP, RESP.
- cmd_ready=1 only in IDLE. A command is accepted on a posedge with cmd_valid & cmd_ready; all fields are latched at that edge.
- Per-op state sequences after acceptance:
  - MOV (R[a]<=R[b]): RD0(id=b, t0<=rf_dout) -> WR0(id=a, write, din=t0) -> RESP. rsp_data=t0.
  - LDI: WR0(id=a, write, din={8'h00,imm[7:0]}) -> WRU(id=a, writeu, din={8'h00,imm[15:8]}) -> RESP. rsp_data=imm.
  - INC / DEC: STEP(id=a, inc or dec) -> RESP. rsp_data=0.
  - SWAP: RD0(id=a, t0) -> RD1(id=b, t1) -> WR0(id=a, din=t1) -> WR1(id=b, din=t0) -> RESP. rsp_data=original R[a].
  - RD: RD0(id=a, t0) -> RESP. rsp_data=t0.
- Error check, done at acceptance:
  - Illegal op, or any id used by the op >= NUM_REGS, goes directly to RESP with rsp_err=1 and rsp_data=0.
  - No rf strobe is asserted for a rejected command.
  - Ids the op does not use are not checked (e.g. INC ignores b).
- rsp_valid=1 in RESP. rsp_data and rsp_err are stable while rsp_valid=1.
- RESP exits to IDLE on a posedge with rsp_ready=1. No command is accepted in the same cycle, so minimum command spacing is one IDLE cycle.
- Latency, counted from the accept edge to the edge at which rsp_valid rises:
  - error: 1 edge
  - INC/DEC, RD: 2 edges
  - MOV, LDI: 3 edges
  - SWAP: 5 edges
- Strobes are one-hot or all-zero every cycle. rf_read=0 in every non-read state so the file releases its bus.
- rf_id=0 and rf_din=0 whenever no strobe is active. rf_din is nonzero only with rf_write or rf_writeu.
- rf_dout is sampled only at the posedge ending an RD0/RD1 cycle.
- Equal ids: SWAP with a==b runs the full sequence and leaves the register unchanged. MOV with a==b rewrites the same value.
- Reset (synchronous) has priority in any state, including mid-sequence:
  - State goes to IDLE; t0/t1, rsp_data and rsp_err are cleared.
  - rsp_valid=0, all strobes 0, rf_id=0, rf_din=0 from the cycle after the reset edge.
  - A partially executed SWAP or LDI is not completed or rolled back.
  - After reset, cmd_ready=1.

Test Plan:
- Reset, then LDI a=3 imm=16'hBEEF -> cycle 1 rf_write id=3 din=16'h00EF; cycle 2 rf_writeu din=16'h00BE; then rsp_valid with rsp_data=BEEF, rsp_err=0; RD a=3 returns BEEF.
- R5=16'hFFFF, INC a=5 -> one rf_inc cycle; RD a=5 returns 16'h0000 (wrap). DEC a=5 then RD returns FFFF.
- R1=1234, R2=ABCD, SWAP a=1 b=2 -> strobe order read, read, write, write; rsp_data=1234; RD gives R1=ABCD, R2=1234. SWAP a=b=7 leaves R7 unchanged.
- MOV a=40 b=2, and separately op=3'b111 -> rsp_err=1, rsp_data=0, no strobe asserted at any cycle.
- Hold rsp_ready=0 for 4 cycles with cmd_valid high -> rsp_valid/rsp_data stable, cmd_ready=0, no rf activity; on release, the next command is accepted after one IDLE cycle.
- Assert rst in the WR0 cycle of a SWAP -> all strobes 0 from the next cycle, rsp_valid never asserted, cmd_ready=1, R[a] holds the partial value.
